// File: rtl/inst_fetcher.sv
// Instruction fetch front end: issues one outstanding read at a time and
// buffers returned words with their PCs in a small FIFO for decode.
module inst_fetcher #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        control_hazard,
  input  logic [63:0] control_hazard_pc_next,
  output logic        i_req_valid,
  input  logic        i_req_ready,
  output logic [63:0] i_req_addr,
  input  logic        i_rsp_valid,
  input  logic [31:0] i_rsp_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [63:0] inst_addr,
  output logic [31:0] inst_bits
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [63:0]      fetch_pc;
  logic [63:0]      req_pc;
  logic             outstanding;
  logic             discard;
  logic [PTR_W:0]   count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [63:0]      addr_mem [FIFO_DEPTH];
  logic [31:0]      bits_mem [FIFO_DEPTH];
  logic             req_fire;
  logic             push;
  logic             pop;

  // Requests stay low in reset and during a redirect so the new target is the first address issued.
  assign i_req_valid = rst && !control_hazard && !outstanding && (count < FULL_CNT);
  assign i_req_addr  = fetch_pc;
  assign req_fire    = i_req_valid && i_req_ready;
  assign push        = i_rsp_valid && !discard && !control_hazard;
  assign inst_valid  = (count != '0);
  assign pop         = inst_valid && inst_ready;

  // Empty FIFO presents zeros so stale storage never leaks onto the decode bus.
  assign inst_addr = inst_valid ? addr_mem[rd_ptr] : '0;
  assign inst_bits = inst_valid ? bits_mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (i_rsp_valid)
        outstanding <= 1'b0;
      if (req_fire) begin
        outstanding <= 1'b1;
        req_pc      <= fetch_pc;
        fetch_pc    <= fetch_pc + 64'd4;
      end
      if (i_rsp_valid && (discard || control_hazard))
        discard <= 1'b0;

      // A redirect flushes the buffer; an in-flight read not yet returned is marked stale.
      if (control_hazard) begin
        fetch_pc <= {control_hazard_pc_next[63:2], 2'b00};
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        if (outstanding && !i_rsp_valid)
          discard <= 1'b1;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)
          rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)
          count <= count + (PTR_W+1)'(1);
        else if (pop && !push)
          count <= count - (PTR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= req_pc;
      bits_mem[wr_ptr] <= i_rsp_rdata;
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher with a latency-programmable memory responder.
module tb_inst_fetcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        control_hazard = 1'b0;
  logic [63:0] control_hazard_pc_next = '0;
  logic        i_req_valid;
  logic        i_req_ready = 1'b0;
  logic [63:0] i_req_addr;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_rdata;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [63:0] inst_addr;
  logic [31:0] inst_bits;

  int n_checks = 0;
  int n_errors = 0;
  int lat = 1;

  logic [63:0] req_q [$];
  logic [95:0] out_q [$];

  logic        m_pend;
  logic [63:0] m_addr;
  int          m_cnt;

  inst_fetcher dut (
    .clk                    (clk),
    .rst                    (rst),
    .control_hazard         (control_hazard),
    .control_hazard_pc_next (control_hazard_pc_next),
    .i_req_valid            (i_req_valid),
    .i_req_ready            (i_req_ready),
    .i_req_addr             (i_req_addr),
    .i_rsp_valid            (i_rsp_valid),
    .i_rsp_rdata            (i_rsp_rdata),
    .inst_valid             (inst_valid),
    .inst_ready             (inst_ready),
    .inst_addr              (inst_addr),
    .inst_bits              (inst_bits)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  // Memory responder, reset together with the fetcher.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend      <= 1'b0;
      m_addr      <= '0;
      m_cnt       <= 0;
      i_rsp_valid <= 1'b0;
      i_rsp_rdata <= '0;
    end else begin
      i_rsp_valid <= 1'b0;
      if (i_req_valid && i_req_ready) begin
        if (lat <= 1) begin
          i_rsp_valid <= 1'b1;
          i_rsp_rdata <= word(i_req_addr);
        end else begin
          m_pend <= 1'b1;
          m_addr <= i_req_addr;
          m_cnt  <= lat - 1;
        end
      end else if (m_pend) begin
        if (m_cnt <= 1) begin
          i_rsp_valid <= 1'b1;
          i_rsp_rdata <= word(m_addr);
          m_pend      <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      if (i_req_valid && i_req_ready) req_q.push_back(i_req_addr);
      if (inst_valid && inst_ready)   out_q.push_back({inst_addr, inst_bits});
    end
  end

  task automatic check_val(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic wait_req(input string tag, input int n);
    for (int i = 0; i < 300 && req_q.size() < n; i++) @(negedge clk);
    check_val(tag, (req_q.size() >= n), 1'b1);
  endtask

  task automatic wait_out(input string tag, input int n);
    for (int i = 0; i < 300 && out_q.size() < n; i++) @(negedge clk);
    check_val(tag, (out_q.size() >= n), 1'b1);
  endtask

  task automatic wait_rsp(input string tag);
    for (int i = 0; i < 300 && !i_rsp_valid; i++) @(negedge clk);
    check_val(tag, i_rsp_valid, 1'b1);
  endtask

  task automatic redirect(input logic [63:0] target);
    control_hazard         = 1'b1;
    control_hazard_pc_next = target;
    @(negedge clk);
    control_hazard         = 1'b0;
  endtask

  initial begin
    int rb;
    int ob;
    logic [63:0] a;

    #3 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_req_valid", i_req_valid, 1'b0);
    check_val("rst_inst_valid", inst_valid, 1'b0);
    check_val("rst_req_addr", i_req_addr, 64'h0);
    check_val("rst_inst_addr", inst_addr, 64'h0);
    check_val("rst_inst_bits", inst_bits, 32'h0);

    // Streaming with 1-cycle memory, stop after three requests.
    i_req_ready = 1'b1;
    inst_ready  = 1'b1;
    lat         = 1;
    rst         = 1'b1;
    for (int i = 0; i < 100 && req_q.size() < 3; i++) @(negedge clk);
    i_req_ready = 1'b0;
    wait_out("s1_out_timeout", 3);
    for (int i = 0; i < 3; i++) begin
      a = 64'(4 * i);
      check_val($sformatf("s1_req%0d", i), req_q[i], a);
      check_val($sformatf("s1_out%0d", i), out_q[i], {a, word(a)});
    end

    // Backpressure from decode fills the buffer.
    rst = 1'b0;
    @(negedge clk);
    rst         = 1'b1;
    inst_ready  = 1'b0;
    i_req_ready = 1'b1;
    lat         = 2;
    rb = req_q.size();
    ob = out_q.size();
    repeat (20) @(negedge clk);
    check_val("s2_req_count", req_q.size() - rb, 4);
    check_val("s2_fifo_count", dut.count, 4);
    check_val("s2_req_valid", i_req_valid, 1'b0);
    check_val("s2_inst_valid", inst_valid, 1'b1);
    check_val("s2_head", {inst_addr, inst_bits}, {64'h0, word(64'h0)});
    inst_ready = 1'b1;
    wait_out("s2_out_timeout", ob + 4);
    for (int i = 0; i < 4; i++) begin
      a = 64'(4 * i);
      check_val($sformatf("s2_out%0d", i), out_q[ob+i], {a, word(a)});
    end
    wait_req("s2_resume_timeout", rb + 5);
    check_val("s2_resume", req_q[rb+4], 64'h10);

    // Redirect while the 0x20 read is outstanding.
    for (int i = 0; i < 300 && !(req_q.size() > 0 && req_q[$] == 64'h20); i++) @(negedge clk);
    check_val("s3_req20_seen", req_q[$], 64'h20);
    redirect(64'h8000_0003);
    check_val("s3_discard", dut.discard, 1'b1);
    check_val("s3_req_addr", i_req_addr, 64'h8000_0000);
    rb = req_q.size();
    ob = out_q.size();
    wait_out("s3_out_timeout", ob + 1);
    check_val("s3_req", req_q[rb], 64'h8000_0000);
    check_val("s3_out", out_q[ob], {64'h8000_0000, word(64'h8000_0000)});

    // Redirect coinciding with a response.
    wait_rsp("s4_rsp_timeout");
    redirect(64'h4000_0000);
    check_val("s4_discard", dut.discard, 1'b0);
    check_val("s4_empty", inst_valid, 1'b0);
    rb = req_q.size();
    ob = out_q.size();
    wait_out("s4_out_timeout", ob + 1);
    check_val("s4_req", req_q[rb], 64'h4000_0000);
    check_val("s4_out", out_q[ob], {64'h4000_0000, word(64'h4000_0000)});

    // PC wrap at the top of the address space.
    wait_rsp("s5_rsp_timeout");
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    rb = req_q.size();
    ob = out_q.size();
    wait_req("s5_req_timeout", rb + 2);
    check_val("s5_req0", req_q[rb], 64'hFFFF_FFFF_FFFF_FFFC);
    check_val("s5_req1", req_q[rb+1], 64'h0);
    wait_out("s5_out_timeout", ob + 2);
    check_val("s5_out0", out_q[ob], {64'hFFFF_FFFF_FFFF_FFFC, word(64'hFFFF_FFFF_FFFF_FFFC)});
    check_val("s5_out1", out_q[ob+1], {64'h0, word(64'h0)});

    // Asynchronous reset with three entries buffered.
    inst_ready = 1'b0;
    for (int i = 0; i < 300 && dut.count != 3; i++) @(negedge clk);
    check_val("s6_count3", dut.count, 3);
    #2 rst = 1'b0;
    #1;
    check_val("s6_req_valid", i_req_valid, 1'b0);
    check_val("s6_inst_valid", inst_valid, 1'b0);
    check_val("s6_req_addr", i_req_addr, 64'h0);
    check_val("s6_inst_addr", inst_addr, 64'h0);
    check_val("s6_inst_bits", inst_bits, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst        = 1'b1;
    inst_ready = 1'b1;
    rb = req_q.size();
    wait_req("s6_req_timeout", rb + 1);
    check_val("s6_first_req", req_q[rb], 64'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
